// File: rtl/anita3_pps_pkg.sv
// rtl/anita3_pps_pkg.sv - state encodings and accept-window helpers for the PPS flywheel
package anita3_pps_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FLYWHEEL = 2'd3
  } state_e;

  // First clocks-in-second value at which an external PPS is believable.
  function automatic int unsigned win_lo(input int unsigned nominal, input int unsigned tol);
    return nominal - tol;
  endfunction

  // Last value to wait for an external PPS before the flywheel fires.
  function automatic int unsigned win_hi(input int unsigned nominal, input int unsigned tol);
    return nominal + tol - 1;
  endfunction

endpackage

// File: rtl/anita3_pps_flywheel.sv
// rtl/anita3_pps_flywheel.sv - PPS validation, period measurement, flywheel substitution
// and second counter in the 250 MHz domain.
module anita3_pps_flywheel
  import anita3_pps_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 28,
  parameter int unsigned NOMINAL_PERIOD = 250000000,
  parameter int unsigned TOLERANCE      = 2500,
  parameter int unsigned MAX_MISS       = 3
) (
  input  logic                 clk250_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 pps_i,
  input  logic                 sec_load_i,
  input  logic [31:0]          sec_value_i,
  output logic                 pps_o,
  output logic                 pps_fly_o,
  output logic                 early_o,
  output logic                 load_pending_o,
  output logic [31:0]          second_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic [CNT_WIDTH-1:0] last_period_o,
  output logic [7:0]           miss_count_o,
  output logic [STATE_W-1:0]   state_o
);

  localparam logic [CNT_WIDTH-1:0] WIN_LO   = CNT_WIDTH'(win_lo(NOMINAL_PERIOD, TOLERANCE));
  localparam logic [CNT_WIDTH-1:0] WIN_HI   = CNT_WIDTH'(win_hi(NOMINAL_PERIOD, TOLERANCE));
  localparam logic [7:0]           MISS_MAX = 8'(MAX_MISS);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0] last_period_q, last_period_d;
  logic [31:0]          second_q, second_d;
  logic [31:0]          load_value_q, load_value_d;
  logic                 load_pending_q, load_pending_d;
  logic [7:0]           miss_q, miss_d;
  logic                 pps_q, pps_d;
  logic                 fly_q, fly_d;
  logic                 early_q, early_d;

  logic                 in_window;
  logic                 at_timeout;
  logic [7:0]           miss_inc;

  assign in_window  = (cycles_q >= WIN_LO);
  assign at_timeout = (cycles_q == WIN_HI);
  assign miss_inc   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    cycles_d       = (cycles_q == '1) ? cycles_q : cycles_q + CNT_WIDTH'(1);
    last_period_d  = last_period_q;
    second_d       = second_q;
    load_value_d   = load_value_q;
    load_pending_d = load_pending_q;
    miss_d         = miss_q;
    pps_d          = 1'b0;
    fly_d          = 1'b0;
    early_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cycles_d = '0;
        state_d  = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (pps_i) begin
          pps_d   = 1'b1;
          miss_d  = 8'd0;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED, ST_FLYWHEEL: begin
        if (pps_i && !in_window) begin
          early_d = 1'b1;
        end else if (pps_i) begin
          // After a flywheel pulse the reference edge was synthetic, so no period sample.
          if (state_q == ST_LOCKED) last_period_d = cycles_q + CNT_WIDTH'(1);
          pps_d   = 1'b1;
          miss_d  = 8'd0;
          state_d = ST_LOCKED;
        end else if (at_timeout) begin
          miss_d = miss_inc;
          if (state_q == ST_FLYWHEEL && miss_inc == MISS_MAX) begin
            state_d = ST_ACQUIRE;
          end else begin
            pps_d   = 1'b1;
            fly_d   = 1'b1;
            state_d = ST_FLYWHEEL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable_i) begin
      state_d  = ST_IDLE;
      cycles_d = '0;
      miss_d   = 8'd0;
      pps_d    = 1'b0;
      fly_d    = 1'b0;
      early_d  = 1'b0;
    end

    if (pps_d) begin
      cycles_d       = '0;
      second_d       = load_pending_q ? load_value_q : second_q + 32'd1;
      load_pending_d = 1'b0;
    end

    // A load arriving on the same edge as a pulse is held for the next pulse.
    if (sec_load_i) begin
      load_pending_d = 1'b1;
      load_value_d   = sec_value_i;
    end
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cycles_q       <= '0;
      last_period_q  <= '0;
      second_q       <= '0;
      load_value_q   <= '0;
      load_pending_q <= 1'b0;
      miss_q         <= '0;
      pps_q          <= 1'b0;
      fly_q          <= 1'b0;
      early_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycles_q       <= cycles_d;
      last_period_q  <= last_period_d;
      second_q       <= second_d;
      load_value_q   <= load_value_d;
      load_pending_q <= load_pending_d;
      miss_q         <= miss_d;
      pps_q          <= pps_d;
      fly_q          <= fly_d;
      early_q        <= early_d;
    end
  end

  assign pps_o          = pps_q;
  assign pps_fly_o      = fly_q;
  assign early_o        = early_q;
  assign load_pending_o = load_pending_q;
  assign second_o       = second_q;
  assign cycles_o       = cycles_q;
  assign last_period_o  = last_period_q;
  assign miss_count_o   = miss_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_anita3_pps_flywheel.sv
// tb/tb_anita3_pps_flywheel.sv - directed bench with a time-anchored reference model
module tb_anita3_pps_flywheel;

  localparam int CW     = 12;
  localparam int CMAX   = 4095;
  localparam int LO     = 990;
  localparam int HI     = 1009;
  localparam int MAXMIS = 3;

  logic          clk250 = 1'b0;
  logic          rst_i = 1'b1, enable_i = 1'b0, pps_i = 1'b0, sec_load_i = 1'b0;
  logic [31:0]   sec_value_i = 32'd0;
  logic          pps_o, pps_fly_o, early_o, load_pending_o;
  logic [31:0]   second_o;
  logic [CW-1:0] cycles_o, last_period_o;
  logic [7:0]    miss_count_o;
  logic [1:0]    state_o;

  int vectors = 0;
  int miscompares = 0;

  int          m_n = 0, m_anchor = 0, m_mode = 0, m_cyc = 0, m_misses = 0, m_last = 0;
  logic [31:0] m_second = 0, m_pval = 0;
  bit          m_pend = 0, m_pps = 0, m_fly = 0, m_early = 0, m_live = 0;

  always #2 clk250 = ~clk250;

  anita3_pps_flywheel #(
    .CNT_WIDTH(CW), .NOMINAL_PERIOD(1000), .TOLERANCE(10), .MAX_MISS(MAXMIS)
  ) dut (
    .clk250_i(clk250), .rst_i(rst_i), .enable_i(enable_i), .pps_i(pps_i),
    .sec_load_i(sec_load_i), .sec_value_i(sec_value_i),
    .pps_o(pps_o), .pps_fly_o(pps_fly_o), .early_o(early_o),
    .load_pending_o(load_pending_o), .second_o(second_o), .cycles_o(cycles_o),
    .last_period_o(last_period_o), .miss_count_o(miss_count_o), .state_o(state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: cycles_o is the distance from the last "zero" instant, clamped.
  task automatic model_step();
    bit restart;
    int cur;
    cur = m_cyc;
    restart = 0;
    m_pps = 0; m_fly = 0; m_early = 0;
    if (rst_i) begin
      m_mode = 0; m_second = 0; m_last = 0; m_misses = 0; m_pend = 0; m_pval = 0;
      restart = 1;
    end else begin
      if (!enable_i) begin
        m_mode = 0; m_misses = 0; restart = 1;
      end else if (m_mode == 0) begin
        m_mode = 1; restart = 1;
      end else if (m_mode == 1) begin
        if (pps_i) begin m_mode = 2; m_misses = 0; m_pps = 1; end
      end else begin
        if (pps_i && cur < LO) m_early = 1;
        else if (pps_i) begin
          if (m_mode == 2) m_last = (cur + 1) % (CMAX + 1);
          m_mode = 2; m_misses = 0; m_pps = 1;
        end else if (cur == HI) begin
          if (m_misses < 255) m_misses = m_misses + 1;
          if (m_misses == MAXMIS) m_mode = 1;
          else begin m_mode = 3; m_pps = 1; m_fly = 1; end
        end
      end
      if (m_pps) begin
        restart = 1;
        m_second = m_pend ? m_pval : m_second + 32'd1;
        m_pend = 0;
      end
      if (sec_load_i) begin m_pend = 1; m_pval = sec_value_i; end
    end
    m_n = m_n + 1;
    if (restart) m_anchor = m_n;
    m_cyc = (m_n - m_anchor > CMAX) ? CMAX : m_n - m_anchor;
    m_live = 1;
  endtask

  initial forever begin
    @(posedge clk250);
    model_step();
  end

  initial forever begin
    @(negedge clk250);
    if (m_live) begin
      check("pps_o",          64'(pps_o),          64'(m_pps));
      check("pps_fly_o",      64'(pps_fly_o),      64'(m_fly));
      check("early_o",        64'(early_o),        64'(m_early));
      check("load_pending_o", 64'(load_pending_o), 64'(m_pend));
      check("second_o",       64'(second_o),       64'(m_second));
      check("cycles_o",       64'(cycles_o),       64'(m_cyc));
      check("last_period_o",  64'(last_period_o),  64'(m_last));
      check("miss_count_o",   64'(miss_count_o),   64'(m_misses));
      check("state_o",        64'(state_o),        64'(m_mode));
    end
  end

  task automatic tick();
    @(negedge clk250);
  endtask

  task automatic pulse_pps();
    pps_i = 1'b1;
    tick();
    pps_i = 1'b0;
  endtask

  task automatic load_sec(input logic [31:0] v);
    sec_value_i = v;
    sec_load_i  = 1'b1;
    tick();
    sec_load_i  = 1'b0;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_cyc != target && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to: cycles budget expired, at %0d required %0d", m_cyc, target);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_state",  64'(state_o),  64'd0);
    check("rst_cycles", 64'(cycles_o), 64'd0);
    check("rst_second", 64'(second_o), 64'd0);
    rst_i = 1'b0;

    // 1: acquire then first measured second
    enable_i = 1'b1;
    tick();
    check("t1_acquire", 64'(state_o), 64'd1);
    repeat (5) tick();
    pulse_pps();
    check("t1_pps0", 64'(pps_o), 64'd1);
    check("t1_locked", 64'(state_o), 64'd2);
    run_to(999);
    pulse_pps();
    check("t1_pps1", 64'(pps_o), 64'd1);
    check("t1_period", 64'(last_period_o), 64'd1000);
    check("t1_second", 64'(second_o), 64'd2);

    // 2: early reject, then short-but-valid second
    run_to(500);
    pulse_pps();
    check("t2_early", 64'(early_o), 64'd1);
    check("t2_no_pps", 64'(pps_o), 64'd0);
    run_to(995);
    pulse_pps();
    check("t2_period", 64'(last_period_o), 64'd996);

    // 3: outage -> two flywheel pulses then drop to acquire
    run_to(HI);
    tick();
    check("t3_fly1", 64'({pps_o, pps_fly_o}), 64'd3);
    check("t3_miss1", 64'(miss_count_o), 64'd1);
    run_to(HI);
    tick();
    check("t3_fly2", 64'({pps_o, pps_fly_o}), 64'd3);
    check("t3_miss2", 64'(miss_count_o), 64'd2);
    run_to(HI);
    tick();
    check("t3_drop_pps", 64'(pps_o), 64'd0);
    check("t3_drop_state", 64'(state_o), 64'd1);

    // 4: recovery from flywheel keeps the last measured period
    pulse_pps();
    run_to(HI);
    tick();
    check("t4_fly_state", 64'(state_o), 64'd3);
    run_to(1000);
    pulse_pps();
    check("t4_ext", 64'({pps_o, pps_fly_o}), 64'd2);
    check("t4_locked", 64'(state_o), 64'd2);
    check("t4_miss0", 64'(miss_count_o), 64'd0);
    check("t4_period", 64'(last_period_o), 64'd996);
    check("t4_second", 64'(second_o), 64'd8);

    // 5: second load, coincident load, overwrite
    load_sec(32'h12345678);
    check("t5_pending", 64'(load_pending_o), 64'd1);
    run_to(995);
    pulse_pps();
    check("t5_loaded", 64'(second_o), 64'h12345678);
    check("t5_cleared", 64'(load_pending_o), 64'd0);
    run_to(999);
    pulse_pps();
    check("t5_incr", 64'(second_o), 64'h12345679);
    load_sec(32'hA5A5A5A5);
    check("t5_coinc_hold", 64'(second_o), 64'h12345679);
    check("t5_coinc_pend", 64'(load_pending_o), 64'd1);
    load_sec(32'h00000011);
    load_sec(32'h00000022);
    run_to(999);
    pulse_pps();
    check("t5_overwrite", 64'(second_o), 64'h22);

    // 6: external at the timeout cycle wins; then reset and disable mid-second
    run_to(HI);
    pulse_pps();
    check("t6_ext_at_hi", 64'({pps_o, pps_fly_o}), 64'd2);
    check("t6_period", 64'(last_period_o), 64'd1010);
    run_to(300);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_rst_state", 64'(state_o), 64'd0);
    check("t6_rst_second", 64'(second_o), 64'd0);
    check("t6_rst_period", 64'(last_period_o), 64'd0);
    repeat (3) tick();
    pulse_pps();
    run_to(200);
    enable_i = 1'b0;
    tick();
    check("t6_dis_state", 64'(state_o), 64'd0);
    check("t6_dis_second", 64'(second_o), 64'd1);
    check("t6_dis_cycles", 64'(cycles_o), 64'd0);
    enable_i = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
